spi_slave_link: RTL and testbench
=================================

# spi_slave_link

Parametrised SPI slave endpoint sitting between an external SPI master (the tracking controller) and the FPGA-side packer/motor datapath. It synchronises `sclk`, `mosi` and `cs` into `clk` and supports all four SPI modes. Each frame, it requests and snapshots a transmit word, shifts full-duplex `FRAME_W` bits MSB-first, and delivers the received word with a one-cycle valid. It also checks frame integrity and keeps good-frame and error counters.

## Interface
- `FRAME_W`, 32: bits per frame; legal range 8..64.
- `SYNC_STAGES`, 2: flip-flop stages per SPI input; minimum 2.
- `CPOL`, 0: idle level of `sclk`.
- `CPHA`, 0: 0 = sample on leading edge, 1 = sample on trailing edge.
- `CNT_W`, 16: width of `frame_cnt`.

- `clk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-high.
- `sclk`, in, 1: SPI clock, asynchronous.
- `mosi`, in, 1: SPI data from master, asynchronous.
- `cs`, in, 1: chip select, active-low, asynchronous.
- `miso`, out, 1: SPI data to master; 0 while `cs` is deasserted.
- `tx_req`, out, 1: one-cycle pulse at start of frame; requests the next `tx_data`.
- `tx_data`, in, FRAME_W: transmit word; captured the cycle after `tx_req`.
- `rx_data`, out, FRAME_W: last complete received word; held between frames.
- `rx_valid`, out, 1: one-cycle pulse when `rx_data` updates.
- `frame_err`, out, 1: one-cycle pulse when `cs` rises on a short frame.
- `busy`, out, 1: high from the detected `cs` fall until the detected `cs` rise.
- `frame_cnt`, out, CNT_W: count of good frames; wraps.
- `err_cnt`, out, 8: count of short frames; saturates at 255.

## Operation
- Synchroniser reset values: `cs` = 1, `sclk` = `CPOL`, `mosi` = 0. Edge detection compares the last sync stage against one extra register.
- Leading edge is rising when `CPOL` = 0 and falling otherwise.
- Sample edge is the leading edge when `CPHA` = 0, else the trailing edge. Shift edge is the opposite edge.
- States:
  - IDLE: waits for a detected `cs` fall. Then pulses `tx_req`, clears the bit counter, and goes to LOAD.
  - LOAD: one cycle. Captures `tx_data` into the tx shift register and drives its MSB on `miso`. Goes to SHIFT.
  - SHIFT: on each sample edge, shifts the synced `mosi` into the rx shift register LSB and increments the bit counter.
    - On each shift edge, shifts the tx register left. When `CPHA` = 1, the first shift edge of the frame is skipped.
    - When the counter reaches `FRAME_W`: copy the rx shifter to `rx_data`, pulse `rx_valid`, increment `frame_cnt`, and go to DONE.
  - DONE: ignores all further `sclk` edges; `miso` holds its value.
- Detected `cs` rise in LOAD or SHIFT: pulse `frame_err`, increment `err_cnt` (saturating), go to IDLE. `rx_data` is left unchanged.
- Detected `cs` rise in DONE: go to IDLE with no error.
- A sample edge and a `cs` rise detected in the same cycle: the `cs` rise wins and the edge is discarded.
- Reset mid-frame: all state clears immediately and the FSM returns to IDLE. If `cs` is still low at reset release, the reset value of the `cs` synchroniser makes this look like a fresh `cs` fall. A new frame therefore starts; it normally ends in `frame_err`.
- Reset values:
  - `miso` = 0, `tx_req` = 0, `rx_valid` = 0, `frame_err` = 0, `busy` = 0.
  - `rx_data` = 0, `frame_cnt` = 0, `err_cnt` = 0.
  - All shift registers and counters = 0.

## Timing
- Input detection latency: `SYNC_STAGES` + 1 clk from a pin change to the internal edge strobe.
- `tx_req` asserts `SYNC_STAGES` + 1 clk after `cs` falls. `tx_data` is captured on the next clk edge. `miso` shows the MSB one clk after capture.
- Master requirements:
  - The first `sclk` edge must come at least `SYNC_STAGES` + 4 clk after `cs` falls.
  - Each `sclk` half-period must be at least `SYNC_STAGES` + 3 clk.
- `miso` changes one clk after each detected shift edge.
- `rx_valid` asserts one clk after the detection of the final (`FRAME_W`-th) sample edge. `rx_data` is valid in the same cycle.
- `frame_err` and `err_cnt` update one clk after the detected `cs` rise.
- Outputs are registered. `miso` is driven from a register, not decoded combinationally from the synced inputs.

## Structure
- Package `spi_pkg`:
  - `spi_state_e` enum: IDLE, LOAD, SHIFT, DONE.
  - `spi_mode_t`: a {CPOL, CPHA} struct.
  - Helper function `sample_on_rise(CPOL, CPHA)`.
- Sub-module `spi_sync`: `SYNC_STAGES`-deep synchroniser with a `RESET_VAL` parameter. It is instantiated three times. `spi_slave_link` holds the FSM, the shifters and the counters.

## Test plan
- Mode 0, `FRAME_W` = 32: master sends 0xA5A5_0F0F with `tx_data` = 0x55FA_507C. Required: `rx_data` = 0xA5A5_0F0F with one `rx_valid` pulse, master receives 0x55FA_507C, `frame_cnt` = 1.
- Repeat for modes 1, 2 and 3 with the same words. Required: identical results in every mode.
- `cs` rises after 17 bits. Required: `frame_err` pulses once, `err_cnt` = 1, `rx_data` unchanged, no `rx_valid`. The next full frame is received correctly.
- 34 `sclk` cycles inside one `cs` window. Required: exactly one `rx_valid` pulse, with the first 32 bits captured; no `frame_err`.
- Assert `reset` mid-frame at bit 10, then release with `cs` high. Required: all outputs return to their reset values, and the following frame completes cleanly.
- 300 short frames. Required: `err_cnt` saturates at 255. `FRAME_W` = 8 build: 0x3C round-trips in both directions.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI slave link.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } spi_state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  // Modes 0 and 3 sample on the rising sclk edge; modes 1 and 2 on the falling edge.
  function automatic logic sample_on_rise(input logic cpol, input logic cpha);
    return cpol == cpha;
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-stage synchroniser for one asynchronous SPI pin, with a configurable reset level.
module spi_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic synced
);

  logic [SYNC_STAGES-1:0] stages;

  // Shift the pin through the synchroniser chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stages <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], pin};
    end
  end

  assign synced = stages[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave_link.sv
// SPI slave endpoint: synchronised inputs, full-duplex MSB-first shifter, frame integrity
// checking with good-frame and short-frame counters.
module spi_slave_link
  import spi_pkg::*;
#(
  parameter int unsigned FRAME_W     = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          CPOL        = 1'b0,
  parameter bit          CPHA        = 1'b0,
  parameter int unsigned CNT_W       = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sclk,
  input  logic               mosi,
  input  logic               cs,
  output logic               miso,
  output logic               tx_req,
  input  logic [FRAME_W-1:0] tx_data,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  output logic               frame_err,
  output logic               busy,
  output logic [CNT_W-1:0]   frame_cnt,
  output logic [7:0]         err_cnt
);

  localparam spi_mode_t   MODE        = '{cpol: CPOL, cpha: CPHA};
  localparam bit          SAMPLE_RISE = sample_on_rise(MODE.cpol, MODE.cpha);
  localparam int unsigned BIT_W       = $clog2(FRAME_W + 1);

  logic cs_s, sclk_s, mosi_s;
  logic cs_q, sclk_q;

  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .reset(reset), .pin(cs), .synced(cs_s)
  );
  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) u_sync_sclk (
    .clk(clk), .reset(reset), .pin(sclk), .synced(sclk_s)
  );
  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .pin(mosi), .synced(mosi_s)
  );

  spi_state_e         state_q, state_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [FRAME_W-1:0] rx_sh_q, rx_sh_d, tx_sh_q, tx_sh_d, rx_data_q, rx_data_d, rx_next;
  logic               skip_q, skip_d, miso_q, miso_d, tx_req_q, tx_req_d;
  logic               rx_valid_q, rx_valid_d, frame_err_q, frame_err_d, busy_q, busy_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [7:0]         err_cnt_q, err_cnt_d, err_cnt_inc;
  logic               cs_fall, cs_rise, sclk_rise, sclk_fall, sample_edge, shift_edge;

  assign cs_fall     = cs_q & ~cs_s;
  assign cs_rise     = ~cs_q & cs_s;
  assign sclk_rise   = ~sclk_q & sclk_s;
  assign sclk_fall   = sclk_q & ~sclk_s;
  assign sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;
  assign shift_edge  = SAMPLE_RISE ? sclk_fall : sclk_rise;
  assign rx_next     = {rx_sh_q[FRAME_W-2:0], mosi_s};
  assign err_cnt_inc = (err_cnt_q == 8'hFF) ? 8'hFF : err_cnt_q + 8'd1;

  // Next-state and output decode; a cs rise takes priority over any sclk edge.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_sh_d     = rx_sh_q;
    tx_sh_d     = tx_sh_q;
    rx_data_d   = rx_data_q;
    skip_d      = skip_q;
    miso_d      = miso_q;
    busy_d      = busy_q;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    tx_req_d    = 1'b0;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          tx_req_d  = 1'b1;
          bit_cnt_d = '0;
          skip_d    = CPHA;
          busy_d    = 1'b1;
          state_d   = LOAD;
        end
      end
      LOAD, SHIFT: begin
        if (cs_rise) begin
          frame_err_d = 1'b1;
          err_cnt_d   = err_cnt_inc;
          busy_d      = 1'b0;
          miso_d      = 1'b0;
          state_d     = IDLE;
        end else if (state_q == LOAD) begin
          tx_sh_d = tx_data;
          miso_d  = tx_data[FRAME_W-1];
          state_d = SHIFT;
        end else if (sample_edge) begin
          rx_sh_d   = rx_next;
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          if (bit_cnt_q == BIT_W'(FRAME_W - 1)) begin
            rx_data_d   = rx_next;
            rx_valid_d  = 1'b1;
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
            state_d     = DONE;
          end
        end else if (shift_edge) begin
          // In CPHA=1 the first shift edge would drop the MSB that LOAD already presented.
          if (skip_q) begin
            skip_d = 1'b0;
          end else begin
            tx_sh_d = tx_sh_q << 1;
            miso_d  = tx_sh_q[FRAME_W-2];
          end
        end
      end
      DONE: begin
        if (cs_rise) begin
          busy_d  = 1'b0;
          miso_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, shifters, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_q        <= 1'b1;
      sclk_q      <= CPOL;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_sh_q     <= '0;
      tx_sh_q     <= '0;
      rx_data_q   <= '0;
      skip_q      <= 1'b0;
      miso_q      <= 1'b0;
      tx_req_q    <= 1'b0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      cs_q        <= cs_s;
      sclk_q      <= sclk_s;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_sh_q     <= rx_sh_d;
      tx_sh_q     <= tx_sh_d;
      rx_data_q   <= rx_data_d;
      skip_q      <= skip_d;
      miso_q      <= miso_d;
      tx_req_q    <= tx_req_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign miso      = miso_q;
  assign tx_req    = tx_req_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;
  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_spi_slave_link.sv
// Directed bench: four 32-bit instances (modes 0..3) and one 8-bit mode-0 instance.
module tb_spi_slave_link;

  localparam int unsigned SYNC = 2;
  localparam int          HALF = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [4:0]  sclk, cs, miso, tx_req, rx_valid, frame_err, busy;
  logic        mosi;
  logic [31:0] tx_word;
  logic [31:0] rx_data [4];
  logic [15:0] frame_cnt [4];
  logic [7:0]  err_cnt [4];
  logic [7:0]  tx_word8, rx_data8, err_cnt8;
  logic [15:0] frame_cnt8;

  for (genvar m = 0; m < 4; m++) begin : g_mode
    localparam int unsigned M = m;
    localparam bit P = M[1];
    localparam bit H = M[0];
    spi_slave_link #(
      .FRAME_W(32), .SYNC_STAGES(SYNC), .CPOL(P), .CPHA(H), .CNT_W(16)
    ) u_dut (
      .clk(clk), .reset(reset), .sclk(sclk[m]), .mosi(mosi), .cs(cs[m]), .miso(miso[m]),
      .tx_req(tx_req[m]), .tx_data(tx_word), .rx_data(rx_data[m]), .rx_valid(rx_valid[m]),
      .frame_err(frame_err[m]), .busy(busy[m]), .frame_cnt(frame_cnt[m]), .err_cnt(err_cnt[m])
    );
  end

  spi_slave_link #(
    .FRAME_W(8), .SYNC_STAGES(SYNC), .CPOL(1'b0), .CPHA(1'b0), .CNT_W(16)
  ) u_dut8 (
    .clk(clk), .reset(reset), .sclk(sclk[4]), .mosi(mosi), .cs(cs[4]), .miso(miso[4]),
    .tx_req(tx_req[4]), .tx_data(tx_word8), .rx_data(rx_data8), .rx_valid(rx_valid[4]),
    .frame_err(frame_err[4]), .busy(busy[4]), .frame_cnt(frame_cnt8), .err_cnt(err_cnt8)
  );

  int n_checks = 0;
  int n_errors = 0;
  int valid_cnt [5] = '{default: 0};
  int err_pulse [5] = '{default: 0};

  // Pulse counters, sampled away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (rx_valid[i]) valid_cnt[i]++;
      if (frame_err[i]) err_pulse[i]++;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic bit tb_cpol(input int idx);
    return (idx < 4) ? idx[1] : 1'b0;
  endfunction

  function automatic bit tb_cpha(input int idx);
    return (idx < 4) ? idx[0] : 1'b0;
  endfunction

  task automatic cs_low(input int idx);
    sclk[idx] = tb_cpol(idx);
    cs[idx]   = 1'b0;
    wait_clk(10);
  endtask

  task automatic cs_high(input int idx);
    cs[idx] = 1'b1;
    wait_clk(10);
  endtask

  // Master side: n sclk cycles, mosi taken MSB-first from word[63:..], miso collected in got.
  task automatic clock_bits(input int idx, input int n, input logic [63:0] word,
                            output logic [63:0] got);
    bit pol = tb_cpol(idx);
    bit pha = tb_cpha(idx);
    got = '0;
    for (int i = 0; i < n; i++) begin
      if (!pha) begin
        mosi = word[63-i];
        wait_clk(HALF);
        sclk[idx] = ~pol;
        got = {got[62:0], miso[idx]};
        wait_clk(HALF);
        sclk[idx] = pol;
      end else begin
        sclk[idx] = ~pol;
        mosi = word[63-i];
        wait_clk(HALF);
        sclk[idx] = pol;
        got = {got[62:0], miso[idx]};
        wait_clk(HALF);
      end
    end
    wait_clk(HALF);
  endtask

  task automatic full_frame(input int idx, input int n, input logic [63:0] word,
                            output logic [63:0] got);
    cs_low(idx);
    clock_bits(idx, n, word, got);
    cs_high(idx);
  endtask

  initial begin
    logic [63:0] got;
    int v0, e0;
    reset    = 1'b1;
    cs       = '1;
    sclk     = 5'b01100;
    mosi     = 1'b0;
    tx_word  = 32'h55FA_507C;
    tx_word8 = 8'h3C;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(3);

    check_eq("reset rx_data", 64'(rx_data[0]), 64'h0);
    check_eq("reset frame_cnt", 64'(frame_cnt[0]), 64'h0);
    check_eq("reset err_cnt", 64'(err_cnt[0]), 64'h0);
    check_eq("reset outputs", 64'({miso, tx_req, busy}), 64'h0);

    for (int m = 0; m < 4; m++) begin
      v0 = valid_cnt[m];
      full_frame(m, 32, {32'hA5A5_0F0F, 32'h0}, got);
      check_eq($sformatf("mode%0d master rx", m), got[31:0], 64'h55FA_507C);
      check_eq($sformatf("mode%0d rx_data", m), 64'(rx_data[m]), 64'hA5A5_0F0F);
      check_eq($sformatf("mode%0d rx_valid pulses", m), 64'(valid_cnt[m] - v0), 64'd1);
      check_eq($sformatf("mode%0d frame_cnt", m), 64'(frame_cnt[m]), 64'd1);
      check_eq($sformatf("mode%0d frame_err pulses", m), 64'(err_pulse[m]), 64'd0);
    end

    // Short frame: 17 bits then cs rise.
    v0 = valid_cnt[0];
    e0 = err_pulse[0];
    full_frame(0, 17, {32'hFFFF_0000, 32'h0}, got);
    check_eq("short frame_err pulses", 64'(err_pulse[0] - e0), 64'd1);
    check_eq("short err_cnt", 64'(err_cnt[0]), 64'd1);
    check_eq("short rx_data held", 64'(rx_data[0]), 64'hA5A5_0F0F);
    check_eq("short no rx_valid", 64'(valid_cnt[0] - v0), 64'd0);
    check_eq("short busy low", 64'(busy[0]), 64'd0);

    tx_word = 32'h0BAD_F00D;
    full_frame(0, 32, {32'h1234_5678, 32'h0}, got);
    check_eq("after short master rx", got[31:0], 64'h0BAD_F00D);
    check_eq("after short rx_data", 64'(rx_data[0]), 64'h1234_5678);
    check_eq("after short frame_cnt", 64'(frame_cnt[0]), 64'd2);

    // 34 sclk cycles in one cs window: only the first 32 bits count.
    tx_word = 32'h55FA_507C;
    v0 = valid_cnt[0];
    e0 = err_pulse[0];
    full_frame(0, 34, {32'hDEAD_BEEF, 32'hC000_0000}, got);
    check_eq("long rx_data", 64'(rx_data[0]), 64'hDEAD_BEEF);
    check_eq("long master rx", 64'(got[33:2]), 64'h55FA_507C);
    check_eq("long rx_valid pulses", 64'(valid_cnt[0] - v0), 64'd1);
    check_eq("long no frame_err", 64'(err_pulse[0] - e0), 64'd0);
    check_eq("long frame_cnt", 64'(frame_cnt[0]), 64'd3);

    // Reset at bit 10, released with cs high.
    cs_low(0);
    clock_bits(0, 10, {32'h0F0F_0F0F, 32'h0}, got);
    reset = 1'b1;
    wait_clk(2);
    cs[0]   = 1'b1;
    sclk[0] = 1'b0;
    wait_clk(4);
    reset = 1'b0;
    e0 = err_pulse[0];
    wait_clk(10);
    check_eq("mid reset rx_data", 64'(rx_data[0]), 64'h0);
    check_eq("mid reset frame_cnt", 64'(frame_cnt[0]), 64'h0);
    check_eq("mid reset err_cnt", 64'(err_cnt[0]), 64'h0);
    check_eq("mid reset miso/busy", 64'({miso[0], busy[0]}), 64'h0);
    check_eq("mid reset no frame_err", 64'(err_pulse[0] - e0), 64'd0);
    full_frame(0, 32, {32'h3355_AACC, 32'h0}, got);
    check_eq("post reset rx_data", 64'(rx_data[0]), 64'h3355_AACC);
    check_eq("post reset master rx", got[31:0], 64'h55FA_507C);
    check_eq("post reset frame_cnt", 64'(frame_cnt[0]), 64'd1);
    check_eq("post reset err_cnt", 64'(err_cnt[0]), 64'd0);

    // 300 empty frames: err_cnt saturates, frame_err still pulses every time.
    e0 = err_pulse[0];
    for (int k = 0; k < 300; k++) begin
      cs[0] = 1'b0;
      wait_clk(8);
      cs[0] = 1'b1;
      wait_clk(8);
    end
    check_eq("sat err_cnt", 64'(err_cnt[0]), 64'd255);
    check_eq("sat frame_err pulses", 64'(err_pulse[0] - e0), 64'd300);
    check_eq("sat frame_cnt", 64'(frame_cnt[0]), 64'd1);

    // 8-bit build.
    v0 = valid_cnt[4];
    full_frame(4, 8, {8'h3C, 56'h0}, got);
    check_eq("w8 master rx", got[7:0], 64'h3C);
    check_eq("w8 rx_data", 64'(rx_data8), 64'h3C);
    check_eq("w8 rx_valid pulses", 64'(valid_cnt[4] - v0), 64'd1);
    check_eq("w8 frame_cnt", 64'(frame_cnt8), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
